fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the immediate extender.
- Holds the PC and fetches the instruction word from instruction memory through a req/ack handshake.
- Presents the instruction, whose bits [31:7] drive the extender's immediate input.
- Consumes the extended immediate (and ALU result for JALR) to compute the next PC on branch/jump.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- WAIT_LIMIT, 255, max cycles to wait for i_ImemAck before declaring a bus error (1..1023).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- o_ImemReq  output  1  fetch request, level held until ack.
- o_ImemAddr  output  32  fetch address (= o_PC).
- i_ImemAck  input  1  memory returns i_ImemData this cycle.
- i_ImemData  input  32  instruction word.
- o_Instr  output  32  registered instruction; [31:7] feeds the extender.
- o_InstrValid  output  1  o_Instr is valid for execute.
- i_Ready  input  1  execute consumes the current instruction this cycle.
- i_PCSrc  input  1  take a branch/jump target instead of PC+4.
- i_JalrSel  input  1  with i_PCSrc, target is the JALR target.
- i_ImmExt  input  32  extended immediate from the extender.
- i_ALUResult  input  32  JALR target sum rs1+imm.
- o_PC  output  32  current PC.
- o_PCPlus4  output  32  o_PC+4, combinational.
- o_Misalign  output  1  sticky: next-PC target not word-aligned.
- o_BusErr  output  1  sticky: ack timeout.

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: state=BOOT, o_PC=RESET_PC, o_Instr=32'h0000_0013 (NOP), o_InstrValid=0, o_ImemReq=0, o_Misalign=0, o_BusErr=0, wait counter=0.
- Reset assertion at any time, including mid-request, returns all of the above immediately.
- FSM states: BOOT, REQ, VALID, HALT.
- BOOT: one cycle after reset release, then REQ. An ack seen in BOOT is ignored.
- REQ:
  - o_ImemReq=1, o_ImemAddr=o_PC.
  - On i_ImemAck: o_Instr<=i_ImemData, counter<=0, go to VALID. Ack in the first REQ cycle is legal (zero wait).
  - Otherwise the counter increments. When the counter reaches WAIT_LIMIT without ack: o_BusErr<=1, go to HALT.
- VALID:
  - o_InstrValid=1, o_ImemReq=0.
  - Hold o_Instr and o_PC stable until i_Ready.
  - On i_Ready, compute next:
    - !i_PCSrc: o_PC+4.
    - i_PCSrc & !i_JalrSel: o_PC+i_ImmExt.
    - i_PCSrc & i_JalrSel: {i_ALUResult[31:1],1'b0}.
  - All sums are 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
  - If next[1:0]!=0: o_Misalign<=1, o_PC unchanged, go to HALT.
  - Otherwise o_PC<=next, go to REQ.
  - i_PCSrc/i_JalrSel/i_ImmExt/i_ALUResult are ignored when i_Ready=0 or outside VALID.
- HALT: o_InstrValid=0, o_ImemReq=0, all registers frozen; left only by reset.
- Latency: one instruction per (wait cycles + 2) clocks. With zero-wait memory and i_Ready tied high, the sequence is REQ, VALID, REQ, ...
- o_InstrValid is registered; it deasserts the cycle after i_Ready is sampled in VALID.
- o_PCPlus4 is combinational from o_PC in every state.

Decomposition:
- Shared package: reset instruction constant (NOP 32'h0000_0013), FSM state encoding (2-bit), PC width constant (32).
- Natural sub-module: next_pc_sel — combinational next-PC selector computing PC+4, PC+imm, JALR target, and the misalignment flag.
- FSM, counter and registers stay in fetch_unit.

Test Plan:
- Reset release, zero-wait memory returning 32'h0000_0093 at addr 0, i_Ready=1:
  - o_ImemAddr=0 in REQ, o_Instr=32'h0000_0093 with o_InstrValid=1 next cycle.
  - o_PC becomes 4 after i_Ready.
- Memory ack after 3 wait cycles:
  - o_ImemReq held high 4 cycles with a stable address; o_InstrValid rises the cycle after ack.
  - Counter does not trip with WAIT_LIMIT=255.
- Branch at o_PC=32'h100, i_PCSrc=1, i_ImmExt=32'hFFFF_FFF0:
  - Next fetch address 32'h0F0.
  - Then JALR with i_ALUResult=32'h205: next PC 32'h204.
- i_PCSrc=1, i_ImmExt=32'h0000_0006 at PC 32'h0: o_Misalign=1, state HALT, no further o_ImemReq, o_PC stays 0.
- Never ack with WAIT_LIMIT=4: o_BusErr=1 after 4 REQ cycles, o_ImemReq drops; a late ack is ignored.
- i_rst_n pulsed low in REQ with a pending request:
  - o_ImemReq=0 and o_PC=RESET_PC asynchronously.
  - An ack arriving during BOOT is ignored; the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   PcWidth  : architectural PC / instruction width
//   NopInstr : instruction presented after reset (addi x0, x0, 0)
//   fetch_state_e : fetch FSM encoding
package fetch_unit_pkg;

  localparam int unsigned PcWidth = 32;
  localparam logic [PcWidth-1:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StReq   = 2'd1,
    StValid = 2'd2,
    StHalt  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage and its surroundings (instruction memory,
// immediate extender, execute stage).
//   master : fetch_unit side (drives o_* signals, samples i_* signals)
//   slave  : environment side (memory / execute / extender)
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  // Instruction memory handshake
  logic               o_ImemReq;
  logic [PcWidth-1:0] o_ImemAddr;
  logic               i_ImemAck;
  logic [PcWidth-1:0] i_ImemData;
  // Instruction towards execute / extender
  logic [PcWidth-1:0] o_Instr;
  logic               o_InstrValid;
  logic               i_Ready;
  // Next-PC control from execute
  logic               i_PCSrc;
  logic               i_JalrSel;
  logic [PcWidth-1:0] i_ImmExt;
  logic [PcWidth-1:0] i_ALUResult;
  // PC and status
  logic [PcWidth-1:0] o_PC;
  logic [PcWidth-1:0] o_PCPlus4;
  logic               o_Misalign;
  logic               o_BusErr;

  modport master (
    output o_ImemReq, o_ImemAddr, o_Instr, o_InstrValid, o_PC, o_PCPlus4, o_Misalign, o_BusErr,
    input  i_ImemAck, i_ImemData, i_Ready, i_PCSrc, i_JalrSel, i_ImmExt, i_ALUResult
  );

  modport slave (
    input  o_ImemReq, o_ImemAddr, o_Instr, o_InstrValid, o_PC, o_PCPlus4, o_Misalign, o_BusErr,
    output i_ImemAck, i_ImemData, i_Ready, i_PCSrc, i_JalrSel, i_ImmExt, i_ALUResult
  );

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC selection.
//   pc_i         : current PC
//   pc_src_i     : take branch/jump target instead of PC+4
//   jalr_sel_i   : with pc_src_i, use the JALR target
//   imm_ext_i    : extended immediate (PC-relative offset)
//   alu_result_i : rs1+imm sum for JALR
//   pc_plus4_o   : pc_i + 4
//   next_pc_o    : selected next PC (modulo 2^32)
//   misalign_o   : next_pc_o is not word-aligned
module fetch_unit_next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [PcWidth-1:0] pc_i,
  input  logic               pc_src_i,
  input  logic               jalr_sel_i,
  input  logic [PcWidth-1:0] imm_ext_i,
  input  logic [PcWidth-1:0] alu_result_i,
  output logic [PcWidth-1:0] pc_plus4_o,
  output logic [PcWidth-1:0] next_pc_o,
  output logic               misalign_o
);

  always_comb begin
    pc_plus4_o = pc_i + PcWidth'(4);
    if (!pc_src_i) begin
      next_pc_o = pc_plus4_o;
    end else if (!jalr_sel_i) begin
      next_pc_o = pc_i + imm_ext_i;
    end else begin
      // JALR clears bit 0 of the computed target
      next_pc_o = alu_result_i & ~PcWidth'(1);
    end
    misalign_o = |next_pc_o[1:0];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one instruction per request over a
// req/ack handshake, presents it to execute and steps the PC on i_Ready.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : fetch_unit_if master modport (memory handshake, instruction, next-PC
//             control, PC outputs, sticky Misalign / BusErr flags)
// Parameters:
//   RESET_PC   : PC after reset (word-aligned)
//   WAIT_LIMIT : REQ cycles without ack before declaring a bus error (1..1023)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PcWidth-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned        WAIT_LIMIT = 255
) (
  input logic          i_clk,
  input logic          i_rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned CntWidth = 10;
  localparam logic [CntWidth-1:0] WaitLimit = CntWidth'(WAIT_LIMIT);

  fetch_state_e        state_q, state_d;
  logic [PcWidth-1:0]  pc_q, pc_d;
  logic [PcWidth-1:0]  instr_q, instr_d;
  logic                misalign_q, misalign_d;
  logic                bus_err_q, bus_err_d;
  logic [CntWidth-1:0] wait_cnt_q, wait_cnt_d;

  logic [PcWidth-1:0]  pc_plus4;
  logic [PcWidth-1:0]  next_pc;
  logic                next_misalign;

  fetch_unit_next_pc_sel u_next_pc_sel (
    .pc_i         (pc_q),
    .pc_src_i     (bus.i_PCSrc),
    .jalr_sel_i   (bus.i_JalrSel),
    .imm_ext_i    (bus.i_ImmExt),
    .alu_result_i (bus.i_ALUResult),
    .pc_plus4_o   (pc_plus4),
    .next_pc_o    (next_pc),
    .misalign_o   (next_misalign)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    bus_err_d  = bus_err_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      // Single settle cycle after reset; any ack here is deliberately ignored.
      StBoot: state_d = StReq;

      StReq: begin
        if (bus.i_ImemAck) begin
          instr_d    = bus.i_ImemData;
          wait_cnt_d = '0;
          state_d    = StValid;
        end else begin
          wait_cnt_d = wait_cnt_q + CntWidth'(1);
          if (wait_cnt_q + CntWidth'(1) == WaitLimit) begin
            bus_err_d = 1'b1;
            state_d   = StHalt;
          end
        end
      end

      StValid: begin
        if (bus.i_Ready) begin
          if (next_misalign) begin
            // PC is kept so the faulting instruction's address stays visible
            misalign_d = 1'b1;
            state_d    = StHalt;
          end else begin
            pc_d    = next_pc;
            state_d = StReq;
          end
        end
      end

      StHalt: state_d = StHalt;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      instr_q    <= NopInstr;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Req and valid decode straight from the state register, so both clear the
  // instant reset asserts and valid drops the cycle after i_Ready is taken.
  assign bus.o_ImemReq    = (state_q == StReq);
  assign bus.o_ImemAddr   = pc_q;
  assign bus.o_Instr      = instr_q;
  assign bus.o_InstrValid = (state_q == StValid);
  assign bus.o_PC         = pc_q;
  assign bus.o_PCPlus4    = pc_plus4;
  assign bus.o_Misalign   = misalign_q;
  assign bus.o_BusErr     = bus_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized fetch/retire traffic,
// checked against a PC model computed directly from the next-PC rules.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_w4_n;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_pc;
  logic [31:0] last_instr;

  fetch_unit_if bus ();
  fetch_unit_if bus_w4 ();

  fetch_unit #(
    .RESET_PC   (ResetPc),
    .WAIT_LIMIT (255)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  fetch_unit #(
    .RESET_PC   (ResetPc),
    .WAIT_LIMIT (4)
  ) dut_w4 (
    .i_clk   (clk),
    .i_rst_n (rst_w4_n),
    .bus     (bus_w4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_ImemAck   = 1'b0;
    bus.i_ImemData  = 32'h0;
    bus.i_Ready     = 1'b0;
    bus.i_PCSrc     = 1'b0;
    bus.i_JalrSel   = 1'b0;
    bus.i_ImmExt    = 32'h0;
    bus.i_ALUResult = 32'h0;
  endtask

  // Entered on the first REQ cycle; leaves with the instruction presented (VALID).
  task automatic fetch(input int waits, input logic [31:0] data);
    for (int w = 0; w < waits; w++) begin
      check("req_wait", 32'(bus.o_ImemReq), 32'd1);
      check("addr_wait", bus.o_ImemAddr, exp_pc);
      bus.i_ImemAck = 1'b0;
      tick();
    end
    check("req", 32'(bus.o_ImemReq), 32'd1);
    check("addr", bus.o_ImemAddr, exp_pc);
    bus.i_ImemAck  = 1'b1;
    bus.i_ImemData = data;
    tick();
    bus.i_ImemAck  = 1'b0;
    last_instr     = data;
    check("valid", 32'(bus.o_InstrValid), 32'd1);
    check("instr", bus.o_Instr, data);
    check("req_off", 32'(bus.o_ImemReq), 32'd0);
    check("pc_hold", bus.o_PC, exp_pc);
    check("pcplus4", bus.o_PCPlus4, exp_pc + 32'd4);
  endtask

  // Entered in VALID. kind: 0 sequential, 1 PC-relative branch, 2 JALR.
  task automatic retire(input int stall, input int kind, input logic [31:0] imm,
                        input logic [31:0] alu);
    logic [31:0] nxt;
    for (int s = 0; s < stall; s++) begin
      bus.i_Ready     = 1'b0;
      bus.i_PCSrc     = 1'($urandom());
      bus.i_JalrSel   = 1'($urandom());
      bus.i_ImmExt    = $urandom();
      bus.i_ALUResult = $urandom();
      tick();
      check("stall_valid", 32'(bus.o_InstrValid), 32'd1);
      check("stall_pc", bus.o_PC, exp_pc);
      check("stall_instr", bus.o_Instr, last_instr);
    end
    bus.i_Ready     = 1'b1;
    bus.i_PCSrc     = (kind != 0);
    bus.i_JalrSel   = (kind == 2);
    bus.i_ImmExt    = imm;
    bus.i_ALUResult = alu;
    if (kind == 0)      nxt = exp_pc + 32'd4;
    else if (kind == 1) nxt = exp_pc + imm;
    else                nxt = alu & 32'hFFFF_FFFE;
    tick();
    idle_inputs();
    if (nxt[1:0] != 2'b00) begin
      check("misalign_set", 32'(bus.o_Misalign), 32'd1);
      check("misalign_pc", bus.o_PC, exp_pc);
      check("misalign_valid", 32'(bus.o_InstrValid), 32'd0);
      check("misalign_req", 32'(bus.o_ImemReq), 32'd0);
    end else begin
      exp_pc = nxt;
      check("next_pc", bus.o_PC, exp_pc);
      check("next_req", 32'(bus.o_ImemReq), 32'd1);
      check("next_valid", 32'(bus.o_InstrValid), 32'd0);
      check("next_misalign", 32'(bus.o_Misalign), 32'd0);
    end
  endtask

  initial begin
    int          kind;
    logic [31:0] imm;
    logic [31:0] alu;

    idle_inputs();
    bus_w4.i_ImemAck   = 1'b0;
    bus_w4.i_ImemData  = 32'h0;
    bus_w4.i_Ready     = 1'b0;
    bus_w4.i_PCSrc     = 1'b0;
    bus_w4.i_JalrSel   = 1'b0;
    bus_w4.i_ImmExt    = 32'h0;
    bus_w4.i_ALUResult = 32'h0;
    rst_n    = 1'b0;
    rst_w4_n = 1'b0;
    exp_pc   = ResetPc;
    tick();
    tick();

    // Reset state
    check("rst_req", 32'(bus.o_ImemReq), 32'd0);
    check("rst_pc", bus.o_PC, ResetPc);
    check("rst_pcplus4", bus.o_PCPlus4, ResetPc + 32'd4);
    check("rst_instr", bus.o_Instr, 32'h0000_0013);
    check("rst_valid", 32'(bus.o_InstrValid), 32'd0);
    check("rst_misalign", 32'(bus.o_Misalign), 32'd0);
    check("rst_buserr", 32'(bus.o_BusErr), 32'd0);

    // Boot cycle, then zero-wait fetch of 0x93 at address 0 with Ready held high
    rst_n = 1'b1;
    check("boot_req", 32'(bus.o_ImemReq), 32'd0);
    tick();
    bus.i_Ready = 1'b1;
    fetch(0, 32'h0000_0093);
    retire(0, 0, 32'h0, 32'h0);

    // Three wait cycles under WAIT_LIMIT=255, then stalled retire via JALR to 0x100
    fetch(3, 32'hA5A5_0001);
    check("no_buserr", 32'(bus.o_BusErr), 32'd0);
    retire(2, 2, 32'h0, 32'h0000_0101);

    // Backward branch from 0x100, then JALR to 0x205 -> 0x204
    fetch(0, 32'h1234_5678);
    retire(0, 1, 32'hFFFF_FFF0, 32'h0);
    check("branch_target", bus.o_ImemAddr, 32'h0000_00F0);
    fetch(1, 32'h8765_4321);
    retire(1, 2, 32'h0, 32'h0000_0205);
    check("jalr_target", bus.o_ImemAddr, 32'h0000_0204);

    // Wrap from 0xFFFF_FFFC to 0
    fetch(0, 32'h0000_0001);
    retire(0, 2, 32'h0, 32'hFFFF_FFFD);
    fetch(0, 32'h0000_0002);
    retire(0, 0, 32'h0, 32'h0);
    check("wrap_pc", bus.o_PC, 32'h0);

    // Randomized aligned traffic
    for (int n = 0; n < 40; n++) begin
      fetch(int'($urandom_range(0, 3)), $urandom());
      kind = int'($urandom_range(0, 2));
      imm  = $urandom() & 32'hFFFF_FFFC;
      alu  = $urandom() & 32'hFFFF_FFFD;
      retire(int'($urandom_range(0, 2)), kind, imm, alu);
    end

    // Return to 0, then misaligned branch +6 halts with PC kept at 0
    fetch(0, 32'h0000_0003);
    retire(0, 2, 32'h0, 32'h0000_0001);
    fetch(0, 32'h0000_0004);
    retire(0, 1, 32'h0000_0006, 32'h0);
    bus.i_ImemAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_req", 32'(bus.o_ImemReq), 32'd0);
      check("halt_valid", 32'(bus.o_InstrValid), 32'd0);
      check("halt_pc", bus.o_PC, 32'h0);
      check("halt_misalign", 32'(bus.o_Misalign), 32'd1);
    end
    bus.i_ImemAck = 1'b0;

    // Reset out of HALT, step to PC 4, then reset asynchronously with a request pending
    rst_n = 1'b0;
    #1;
    check("async_clr_misalign", 32'(bus.o_Misalign), 32'd0);
    tick();
    rst_n  = 1'b1;
    exp_pc = ResetPc;
    tick();
    fetch(0, 32'h0000_0005);
    retire(0, 0, 32'h0, 32'h0);
    tick();
    check("pending_req", 32'(bus.o_ImemReq), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", 32'(bus.o_ImemReq), 32'd0);
    check("async_pc", bus.o_PC, ResetPc);
    check("async_instr", bus.o_Instr, 32'h0000_0013);
    check("async_valid", 32'(bus.o_InstrValid), 32'd0);
    bus.i_ImemAck  = 1'b1;
    bus.i_ImemData = 32'hDEAD_BEEF;
    #2;
    rst_n  = 1'b1;
    exp_pc = ResetPc;
    tick();
    check("boot_ack_ignored_req", 32'(bus.o_ImemReq), 32'd1);
    check("boot_ack_ignored_valid", 32'(bus.o_InstrValid), 32'd0);
    check("boot_ack_ignored_instr", bus.o_Instr, 32'h0000_0013);
    check("restart_addr", bus.o_ImemAddr, ResetPc);
    tick();
    bus.i_ImemAck = 1'b0;
    check("restart_valid", 32'(bus.o_InstrValid), 32'd1);
    check("restart_instr", bus.o_Instr, 32'hDEAD_BEEF);

    // WAIT_LIMIT=4 instance never acked: four REQ cycles then bus error
    rst_w4_n = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      check("w4_req", 32'(bus_w4.o_ImemReq), 32'd1);
      check("w4_addr", bus_w4.o_ImemAddr, ResetPc);
      check("w4_no_err", 32'(bus_w4.o_BusErr), 32'd0);
      tick();
    end
    check("w4_buserr", 32'(bus_w4.o_BusErr), 32'd1);
    check("w4_req_drop", 32'(bus_w4.o_ImemReq), 32'd0);
    bus_w4.i_ImemAck  = 1'b1;
    bus_w4.i_ImemData = 32'hCAFE_F00D;
    tick();
    tick();
    check("w4_late_ack_valid", 32'(bus_w4.o_InstrValid), 32'd0);
    check("w4_late_ack_instr", bus_w4.o_Instr, 32'h0000_0013);
    check("w4_late_ack_req", 32'(bus_w4.o_ImemReq), 32'd0);
    check("w4_buserr_sticky", 32'(bus_w4.o_BusErr), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
